alu_exec: RTL and testbench
===========================

# alu_exec

Execute-stage ALU for the simplified MIPS datapath, sitting directly downstream of the ALU control decoder and consuming its 4-bit operation code. It performs single-cycle logic and arithmetic (AND, OR, ADD, SUB, SLT) and adds the iterative unsigned multiply and divide that the decoder's code space reserves. Every operation uses a start/busy/done handshake so the core controller can stall on multi-cycle ops.

## Interface
- WIDTH, 32, operand and result width. Multiply and divide take WIDTH iteration cycles.
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- alu_op  input  4  operation code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 MULU, 1001 DIVU
- src_a  input  WIDTH  operand A (multiplicand / dividend)
- src_b  input  WIDTH  operand B (multiplier / divisor)
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse; result, hi, zero and ovf are valid in that cycle
- result  output  WIDTH  primary result (product low half / quotient for MULU/DIVU)
- hi  output  WIDTH  product high half (MULU), remainder (DIVU), 0 for all other ops
- zero  output  1  result == 0, registered with result
- ovf  output  1  signed overflow for ADD/SUB, 0 for all other ops

## Operation
- States: IDLE, ITER, DONE. Reset forces IDLE; iteration counter, result, hi, zero, ovf and done all reset to 0; busy is 0.
- IDLE with start=1: alu_op, src_a and src_b are latched into internal registers. Inputs may then change freely.
  - Single-cycle op: result, hi, zero and ovf are computed and registered; next state is DONE.
  - MULU/DIVU: the accumulator, counter=0 and the operand registers are loaded; next state is ITER.
- IDLE with start=0: hold. Outputs keep their last values.
- ITER: one step per cycle for exactly WIDTH cycles. The counter increments, and ITER→DONE when counter == WIDTH-1. On that edge, result, hi and zero are written.
  - MULU: shift-add. Full 2·WIDTH-bit unsigned product: low half → result, high half → hi.
  - DIVU: restoring division. Quotient → result, remainder → hi.
  - Divide by zero needs no special case. The natural result is quotient all-ones and remainder = src_a.
- DONE: done=1 for exactly one cycle, then IDLE. A start that arrives during ITER or DONE is ignored and not queued.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - ovf = operand signs equal (ADD) or different (SUB) and result sign differs from src_a.
  - SLT is a signed compare, result = 0…01 or 0.
  - MULU/DIVU are unsigned and set ovf=0.
- Unknown alu_op: result=0, hi=0, zero=1, ovf=0, treated as single-cycle (DONE next cycle).
- Reset asserted mid-ITER: the operation is aborted immediately and all outputs go to reset values. No done pulse occurs for the aborted op.

## Timing
- start accepted at edge N (IDLE):
  - Single-cycle op: done=1 and outputs valid in cycle N+1. busy is high in cycle N+1 only.
  - MULU/DIVU: ITER occupies cycles N+1…N+WIDTH. done=1 in cycle N+WIDTH+1. busy is high in cycles N+1…N+WIDTH+1.
- The earliest next accepted start is the edge ending the DONE cycle (state IDLE in the following cycle samples start). Throughput is one single-cycle op per 2 cycles and one MULU/DIVU per WIDTH+2 cycles.
- result/hi/zero/ovf change only on the edge entering DONE. They are stable during ITER and hold after DONE until the next completion.
- No combinational path from inputs to outputs.

## Test plan
- Reset: assert reset mid-MULU at ITER cycle 10 → busy, done, result, hi, zero, ovf all 0 immediately (asynchronous). After release, state is IDLE.
- Single-cycle ops: ADD 0x7FFFFFFF+1 → result 0x80000000, ovf=1, done at N+1. SUB 5−5 → zero=1. SLT −1 vs 1 → result 1. AND/OR of 0xF0F0F0F0 and 0x0FF00FF0 → 0x00F000F0 / 0xFFF0FFF0.
- MULU 0xFFFFFFFF×0xFFFFFFFF → hi 0xFFFFFFFE, result 0x00000001. done only at N+33, busy N+1…N+33.
- DIVU 100÷7 → result 14, hi 2 at N+33. DIVU 0x1234÷0 → result 0xFFFFFFFF, hi 0x1234.
- Handshake: pulse start with ADD during MULU ITER and during DONE → ignored; MULU result is unaffected and no extra done pulse occurs. Then hold start high continuously with ADD → done pulses every 2 cycles.
- Unknown op 0101 → result 0, hi 0, zero 1, done at N+1. Randomized back-to-back mix checked against a reference model.

Source files
------------

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with single-cycle logic/arith ops and iterative MULU/DIVU behind a start/busy/done handshake
module alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                           OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_MULU = 4'b1000,
                           OP_DIVU = 4'b1001;
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
    state_t             state, state_nx;
    logic [3:0]         op;
    logic [WIDTH-1:0]   opnd, add_r, sub_r, sc_res;
    logic [2*WIDTH-1:0] acc, acc_nx;
    logic [WIDTH:0]     mul_sum, div_rem, div_diff;
    logic [CW-1:0]      cnt;
    logic               multi, last, sc_ovf;
    assign busy  = state != IDLE;
    assign done  = state == DONE;
    assign multi = alu_op == OP_MULU || alu_op == OP_DIVU;
    assign last  = cnt == CW'(WIDTH - 1);
    always_comb begin
        state_nx = state == IDLE ? (start ? (multi ? ITER : DONE) : IDLE)
                 : state == ITER ? (last ? DONE : ITER) : IDLE;
        add_r = src_a + src_b;
        sub_r = src_a - src_b;
        sc_res = '0;
        case (alu_op)
            OP_AND:  sc_res = src_a & src_b;
            OP_OR:   sc_res = src_a | src_b;
            OP_ADD:  sc_res = add_r;
            OP_SUB:  sc_res = sub_r;
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            default: sc_res = '0;
        endcase
        sc_ovf = alu_op == OP_ADD ? (src_a[WIDTH-1] == src_b[WIDTH-1]) && (add_r[WIDTH-1] != src_a[WIDTH-1])
               : alu_op == OP_SUB ? (src_a[WIDTH-1] != src_b[WIDTH-1]) && (sub_r[WIDTH-1] != src_a[WIDTH-1])
               : 1'b0;
        // acc holds {partial product, multiplier} for MULU and {remainder, dividend/quotient} for DIVU
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_rem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff = div_rem - {1'b0, opnd};
        acc_nx = op == OP_MULU ? {mul_sum, acc[WIDTH-1:1]}
               : {div_diff[WIDTH] ? div_rem[WIDTH-1:0] : div_diff[WIDTH-1:0], acc[WIDTH-2:0], ~div_diff[WIDTH]};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            op     <= '0;
            opnd   <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            hi     <= '0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                op   <= alu_op;
                opnd <= alu_op == OP_MULU ? src_a : src_b;
                acc  <= {{WIDTH{1'b0}}, alu_op == OP_MULU ? src_b : src_a};
                cnt  <= '0;
                if (!multi) begin
                    result <= sc_res;
                    hi     <= '0;
                    zero   <= sc_res == '0;
                    ovf    <= sc_ovf;
                end
            end else if (state == ITER) begin
                acc <= acc_nx;
                cnt <= cnt + 1'b1;
                if (last) begin
                    result <= acc_nx[WIDTH-1:0];
                    hi     <= acc_nx[2*WIDTH-1:WIDTH];
                    zero   <= acc_nx[WIDTH-1:0] == '0;
                    ovf    <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: scoreboard bench for alu_exec; directed vectors plus a model-checked random mix
module tb_alu_exec;
    typedef struct {
        logic [31:0] r;
        logic [31:0] h;
        logic        z;
        logic        o;
        int          cyc;
        string       name;
    } exp_t;
    logic        clk = 0, reset = 1, start = 0;
    logic [3:0]  alu_op = 0;
    logic [31:0] src_a = 0, src_b = 0;
    logic        busy, done, zero, ovf;
    logic [31:0] result, hi;
    int          checks = 0, errors = 0, cyc = 0;
    exp_t        sb[$];
    alu_exec #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .alu_op(alu_op), .src_a(src_a), .src_b(src_b),
        .busy(busy), .done(done), .result(result), .hi(hi), .zero(zero), .ovf(ovf)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask
    function automatic exp_t mk(input logic [31:0] r, input logic [31:0] h, input logic z, input logic o, input string n);
        exp_t e;
        e.r = r; e.h = h; e.z = z; e.o = o; e.cyc = 0; e.name = n;
        return e;
    endfunction
    // Independent reference: native wide arithmetic and integer division
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint s;
        logic [63:0] p;
        e = mk(0, 0, 0, 0, "rand");
        case (op)
            4'b0000: e.r = a & b;
            4'b0001: e.r = a | b;
            4'b0010: begin e.r = a + b; s = longint'($signed(a)) + longint'($signed(b)); e.o = s > 64'sd2147483647 || s < -64'sd2147483648; end
            4'b0110: begin e.r = a - b; s = longint'($signed(a)) - longint'($signed(b)); e.o = s > 64'sd2147483647 || s < -64'sd2147483648; end
            4'b0111: e.r = $signed(a) < $signed(b) ? 32'd1 : 32'd0;
            4'b1000: begin p = {32'b0, a} * {32'b0, b}; e.r = p[31:0]; e.h = p[63:32]; end
            4'b1001: begin e.r = b == 0 ? 32'hFFFFFFFF : a / b; e.h = b == 0 ? a : a % b; end
            default: e.r = 0;
        endcase
        e.z = e.r == 0;
        return e;
    endfunction
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, ".result"}, 64'(result), 64'(e.r));
                chk({e.name, ".hi"}, 64'(hi), 64'(e.h));
                chk({e.name, ".zero"}, 64'(zero), 64'(e.z));
                chk({e.name, ".ovf"}, 64'(ovf), 64'(e.o));
                chk({e.name, ".done_cycle"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input exp_t e);
        int lat, bc;
        lat = (op == 4'b1000 || op == 4'b1001) ? 33 : 1;
        e.cyc = cyc + lat;
        sb.push_back(e);
        start = 1; alu_op = op; src_a = a; src_b = b;
        @(negedge clk);
        start = 0; alu_op = 4'($urandom); src_a = $urandom; src_b = $urandom;
        bc = 0;
        while (busy && bc < 40) begin
            bc++;
            @(negedge clk);
        end
        chk({e.name, ".busy_cycles"}, 64'(bc), 64'(lat));
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        int   c, bc;
        exp_t e;
        logic [3:0] ops [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b0011};
        repeat (2) @(negedge clk);
        chk("rst.busy", 64'(busy), 0);
        chk("rst.done", 64'(done), 0);
        chk("rst.result", 64'(result), 0);
        chk("rst.zero", 64'(zero), 0);
        reset = 0;
        @(negedge clk);
        issue(4'b0010, 32'h7FFFFFFF, 32'h1, mk(32'h80000000, 0, 0, 1, "add_ovf"));
        // Abort a MULU in its tenth ITER cycle; outputs must clear without waiting for an edge
        start = 1; alu_op = 4'b1000; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF;
        @(negedge clk);
        start = 0;
        repeat (9) @(negedge clk);
        chk("abort.busy_before", 64'(busy), 1);
        reset = 1;
        #1;
        chk("abort.busy", 64'(busy), 0);
        chk("abort.done", 64'(done), 0);
        chk("abort.result", 64'(result), 0);
        chk("abort.hi", 64'(hi), 0);
        chk("abort.zero", 64'(zero), 0);
        chk("abort.ovf", 64'(ovf), 0);
        @(negedge clk);
        reset = 0;
        repeat (2) @(negedge clk);
        chk("abort.idle_busy", 64'(busy), 0);
        issue(4'b0010, 32'd3, 32'd4, mk(32'd7, 0, 0, 0, "add"));
        issue(4'b0110, 32'd5, 32'd5, mk(32'd0, 0, 1, 0, "sub_zero"));
        issue(4'b0110, 32'h80000000, 32'd1, mk(32'h7FFFFFFF, 0, 0, 1, "sub_ovf"));
        issue(4'b0111, 32'hFFFFFFFF, 32'd1, mk(32'd1, 0, 0, 0, "slt_true"));
        issue(4'b0111, 32'd1, 32'hFFFFFFFF, mk(32'd0, 0, 1, 0, "slt_false"));
        issue(4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, mk(32'h00F000F0, 0, 0, 0, "and"));
        issue(4'b0001, 32'hF0F0F0F0, 32'h0FF00FF0, mk(32'hFFF0FFF0, 0, 0, 0, "or"));
        issue(4'b0101, 32'h12345678, 32'h9ABCDEF0, mk(32'd0, 0, 1, 0, "unknown"));
        issue(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, mk(32'h00000001, 32'hFFFFFFFE, 0, 0, "mulu_max"));
        issue(4'b1000, 32'd3, 32'd5, mk(32'd15, 0, 0, 0, "mulu_small"));
        issue(4'b1000, 32'h00010000, 32'h00010000, mk(32'd0, 32'd1, 1, 0, "mulu_carry"));
        issue(4'b1001, 32'd100, 32'd7, mk(32'd14, 32'd2, 0, 0, "divu"));
        issue(4'b1001, 32'h1234, 32'd0, mk(32'hFFFFFFFF, 32'h1234, 0, 0, "divu_zero"));
        // Starts during ITER and DONE must be dropped; outputs must hold the previous result during ITER
        c = cyc;
        e = mk(32'h23456780, 32'h1, 0, 0, "mulu_ignored");
        e.cyc = c + 33;
        sb.push_back(e);
        start = 1; alu_op = 4'b1000; src_a = 32'h12345678; src_b = 32'h10;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        start = 1; alu_op = 4'b0010; src_a = 1; src_b = 1;
        @(negedge clk);
        start = 0;
        chk("iter.result_hold", 64'(result), 64'h0FFFFFFFF);
        chk("iter.hi_hold", 64'(hi), 64'h1234);
        bc = 0;
        while (!done && bc < 40) begin
            bc++;
            @(negedge clk);
        end
        chk("ignored.done_cycle", 64'(cyc), 64'(c + 33));
        start = 1; alu_op = 4'b0010; src_a = 1; src_b = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        chk("ignored.busy_after", 64'(busy), 0);
        // Start held high: one ADD accepted every other cycle
        c = cyc;
        for (int i = 0; i < 4; i++) begin
            e = mk(32'h30, 0, 0, 0, "add_held");
            e.cyc = c + 1 + 2 * i;
            sb.push_back(e);
        end
        start = 1; alu_op = 4'b0010; src_a = 32'h10; src_b = 32'h20;
        repeat (7) @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, b;
            logic [3:0]  op;
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            op = ops[$urandom_range(0, 7)];
            issue(op, a, b, model(op, a, b));
        end
        repeat (5) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
